// File: rtl/dem_seq_ctrl_pkg.sv
// Shared definitions for the cascaded modulo counter run controller.
package dem_pkg;

   // Controller state encoding, also exported on the state output.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Moduli loaded at reset.
   localparam int DEF_MOD_LO = 4;
   localparam int DEF_MOD_HI = 5;

   // Smallest modulus a stage may run with; smaller writes are raised to this.
   localparam int MIN_MOD = 2;

endpackage

// File: rtl/dem_seq_ctrl_stage.sv
// Generic mod-M counter stage. Advances on en, wraps at mod-1, and reports
// carry in the same cycle it wraps so the next stage can use it as an enable.
module dem_stage #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] mod,
   output logic [W-1:0] count,
   output logic         carry
);

   logic [W-1:0] count_q, count_d;
   logic         at_top;

   // Next count: clear wins over enable; wrap to zero at the top value.
   always_comb begin
      at_top  = (count_q == (mod - W'(1)));
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = at_top ? '0 : (count_q + W'(1));
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign carry = en && at_top;

endmodule

// File: rtl/dem_seq_ctrl.sv
// Run controller for a two-stage cascaded modulo counter: start/stop/pause/
// clear sequencing, runtime moduli, one-shot vs continuous, terminal pulse.
//
// Handshake: there is no valid/ready flow here. Commands and cfg_we are
// single-cycle level samples taken on every rising edge; priority is
// rst > clear > stop > start, and tick is ignored whenever a transition is taken.
module dem_seq_ctrl
   import dem_pkg::*;
#(
   parameter int W_LO       = 3,
   parameter int W_HI       = 3,
   parameter int DEF_MOD_LO = dem_pkg::DEF_MOD_LO,
   parameter int DEF_MOD_HI = dem_pkg::DEF_MOD_HI
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   input  logic                 cfg_we,
   input  logic [W_LO-1:0]      cfg_mod_lo,
   input  logic [W_HI-1:0]      cfg_mod_hi,
   input  logic                 cfg_oneshot,
   output logic [W_LO-1:0]      q_lo,
   output logic [W_HI-1:0]      q_hi,
   output logic [W_LO+W_HI-1:0] q,
   output logic                 ra,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err,
   output logic [1:0]           state
);

   localparam int WQ = W_LO + W_HI;

   state_e          state_q, state_d;
   logic [W_LO-1:0] mod_lo_q, mod_lo_d;
   logic [W_HI-1:0] mod_hi_q, mod_hi_d;
   logic            oneshot_q, oneshot_d;
   logic [WQ-1:0]   q_q, q_d;
   logic            ra_q, ra_d;
   logic            cfg_err_q, cfg_err_d;

   logic            adv;
   logic            en_lo;
   logic            cnt_clr;
   logic            term;
   logic            lo_carry;
   logic            hi_carry_unused;
   logic [W_LO-1:0] lo_cnt;
   logic [W_HI-1:0] hi_cnt;
   logic [W_LO-1:0] cfg_lo_clamped;
   logic [W_HI-1:0] cfg_hi_clamped;

   dem_stage #(.W(W_LO)) u_lo (
      .clk   (clk),
      .rst   (rst),
      .en    (en_lo),
      .clr   (cnt_clr),
      .mod   (mod_lo_q),
      .count (lo_cnt),
      .carry (lo_carry)
   );

   dem_stage #(.W(W_HI)) u_hi (
      .clk   (clk),
      .rst   (rst),
      .en    (lo_carry),
      .clr   (cnt_clr),
      .mod   (mod_hi_q),
      .count (hi_cnt),
      .carry (hi_carry_unused)
   );

   // Next-state, count control, terminal pulse and configuration acceptance.
   always_comb begin
      state_d   = state_q;
      mod_lo_d  = mod_lo_q;
      mod_hi_d  = mod_hi_q;
      oneshot_d = oneshot_q;
      q_d       = q_q;
      ra_d      = 1'b0;
      cfg_err_d = 1'b0;
      adv       = 1'b0;
      cnt_clr   = 1'b0;

      term = (lo_cnt == (mod_lo_q - W_LO'(1))) && (hi_cnt == (mod_hi_q - W_HI'(1)));

      cfg_lo_clamped = (cfg_mod_lo < W_LO'(MIN_MOD)) ? W_LO'(MIN_MOD) : cfg_mod_lo;
      cfg_hi_clamped = (cfg_mod_hi < W_HI'(MIN_MOD)) ? W_HI'(MIN_MOD) : cfg_mod_hi;

      if (clear) begin
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_RUN;
                  cnt_clr = 1'b1;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_d = ST_PAUSE;
               end else if (tick) begin
                  adv = 1'b1;
                  if (term) begin
                     ra_d = 1'b1;
                     if (oneshot_q) state_d = ST_DONE;
                  end
               end
            end
            ST_PAUSE: begin
               if (start && !stop) state_d = ST_RUN;
            end
            ST_DONE: begin
               if (start) begin
                  state_d = ST_RUN;
                  cnt_clr = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // One-shot terminal holds the counts at N-1 instead of wrapping.
      en_lo = adv && !(term && oneshot_q);

      if (cnt_clr) begin
         q_d = '0;
      end else if (en_lo) begin
         q_d = term ? '0 : (q_q + WQ'(1));
      end

      if (cfg_we) begin
         if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            mod_lo_d  = cfg_lo_clamped;
            mod_hi_d  = cfg_hi_clamped;
            oneshot_d = cfg_oneshot;
         end else begin
            cfg_err_d = 1'b1;
         end
      end
   end

   // Controller, configuration and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mod_lo_q  <= W_LO'(DEF_MOD_LO);
         mod_hi_q  <= W_HI'(DEF_MOD_HI);
         oneshot_q <= 1'b0;
         q_q       <= '0;
         ra_q      <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mod_lo_q  <= mod_lo_d;
         mod_hi_q  <= mod_hi_d;
         oneshot_q <= oneshot_d;
         q_q       <= q_d;
         ra_q      <= ra_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign q_lo    = lo_cnt;
   assign q_hi    = hi_cnt;
   assign q       = q_q;
   assign ra      = ra_q;
   assign cfg_err = cfg_err_q;
   assign state   = state_q;
   assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_dem_seq_ctrl.sv
// Bench for dem_seq_ctrl: directed scenarios plus a randomized stretch, all
// compared every cycle against a linear-count reference model.
module tb_dem_seq_ctrl;

   localparam int W_LO = 3;
   localparam int W_HI = 3;
   localparam int D_LO = 4;
   localparam int D_HI = 5;

   logic clk = 1'b0;
   logic rst, tick, start, stop, clear, cfg_we, cfg_oneshot;
   logic [W_LO-1:0]      cfg_mod_lo, q_lo;
   logic [W_HI-1:0]      cfg_mod_hi, q_hi;
   logic [W_LO+W_HI-1:0] q;
   logic                 ra, busy, done, cfg_err;
   logic [1:0]           state;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: one linear count k plus the run mode.
   int m_state;   // 0 idle, 1 run, 2 pause, 3 done
   int m_k, m_qlo, m_qhi, m_mlo, m_mhi;
   bit m_os, m_ra, m_err;

   always #5 clk = ~clk;

   dem_seq_ctrl #(.W_LO(W_LO), .W_HI(W_HI), .DEF_MOD_LO(D_LO), .DEF_MOD_HI(D_HI)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
      .cfg_we(cfg_we), .cfg_mod_lo(cfg_mod_lo), .cfg_mod_hi(cfg_mod_hi),
      .cfg_oneshot(cfg_oneshot), .q_lo(q_lo), .q_hi(q_hi), .q(q), .ra(ra),
      .busy(busy), .done(done), .cfg_err(cfg_err), .state(state)
   );

   function automatic int clamp(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   function automatic void set_k(input int v);
      m_k   = v;
      m_qlo = v % m_mlo;
      m_qhi = v / m_mlo;
   endfunction

   function automatic void model_step();
      m_ra  = 1'b0;
      m_err = 1'b0;
      if (rst) begin
         m_state = 0; m_mlo = D_LO; m_mhi = D_HI; m_os = 1'b0;
         set_k(0);
         return;
      end
      if (cfg_we && (m_state == 1 || m_state == 2)) m_err = 1'b1;
      if (clear) begin
         m_state = 0;
         set_k(0);
      end else begin
         case (m_state)
            0: if (start) begin m_state = 1; set_k(0); end
            1: begin
               if (stop) m_state = 2;
               else if (tick) begin
                  if (m_k == m_mlo * m_mhi - 1) begin
                     m_ra = 1'b1;
                     if (m_os) m_state = 3;
                     else set_k(0);
                  end else begin
                     set_k(m_k + 1);
                  end
               end
            end
            2: if (start && !stop) m_state = 1;
            default: if (start) begin m_state = 1; set_k(0); end
         endcase
      end
      // Configuration was sampled in IDLE/DONE; it lands after this cycle's counting.
      if (cfg_we && !m_err) begin
         m_mlo = clamp(int'(cfg_mod_lo));
         m_mhi = clamp(int'(cfg_mod_hi));
         m_os  = cfg_oneshot;
      end
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
   endtask

   task automatic check_outputs();
      chk("state",   16'(state),   16'(m_state));
      chk("q",       16'(q),       16'(m_k));
      chk("q_lo",    16'(q_lo),    16'(m_qlo));
      chk("q_hi",    16'(q_hi),    16'(m_qhi));
      chk("ra",      16'(ra),      16'(m_ra));
      chk("busy",    16'(busy),    16'(m_state == 1 || m_state == 2));
      chk("done",    16'(done),    16'(m_state == 3));
      chk("cfg_err", 16'(cfg_err), 16'(m_err));
   endtask

   // Apply one cycle of inputs (called at a falling edge), then compare.
   task automatic drive(input bit t, input bit s, input bit p, input bit c,
                        input bit w, input bit r);
      tick = t; start = s; stop = p; clear = c; cfg_we = w; rst = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_cfg(input int lo, input int hi, input bit os);
      cfg_mod_lo  = W_LO'(lo);
      cfg_mod_hi  = W_HI'(hi);
      cfg_oneshot = os;
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; cfg_we = 1'b0;
      set_cfg(D_LO, D_HI, 1'b0);
      m_mlo = D_LO; m_mhi = D_HI;
      @(negedge clk);

      // Reset, then continuous 4x5 run with tick held high.
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(1, 0, 1, 0, 0, 0);          // stop and tick ignored in IDLE
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 45; i++) drive(1, 0, 0, 0, 0, 0);

      // One-shot period, then restart from DONE.
      drive(0, 0, 0, 1, 0, 0);
      set_cfg(D_LO, D_HI, 1'b1);
      drive(0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 25; i++) drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);

      // Pause and resume in continuous mode.
      drive(0, 0, 0, 1, 0, 0);
      set_cfg(D_LO, D_HI, 1'b0);
      drive(0, 1, 0, 0, 1, 0);          // config applied to this run
      for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);          // start+stop in RUN pauses
      drive(1, 1, 1, 0, 0, 0);          // start+stop in PAUSE stays
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);

      // Small moduli, rejected writes while running, clamping.
      drive(0, 0, 0, 1, 0, 0);
      set_cfg(3, 2, 1'b0);
      drive(0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) drive(1, 0, 0, 0, 0, 0);
      set_cfg($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      drive(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0);          // rejected in PAUSE too
      drive(0, 0, 0, 1, 0, 0);
      set_cfg(1, 2, 1'b0);
      drive(0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0);

      // All commands at once, then reset mid-run restores defaults.
      drive(0, 0, 0, 1, 0, 0);
      set_cfg(D_LO, D_HI, 1'b0);
      drive(0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 13; i++) drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 1, 0, 0);
      set_cfg(3, 3, 1'b0);
      drive(0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 22; i++) drive(1, 0, 0, 0, 0, 0);

      // Tick every other cycle: ra every 40 clocks.
      for (int i = 0; i < 84; i++) drive(1'(i % 2), 0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         set_cfg($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
         drive(1'($urandom_range(0, 1)),
               $urandom_range(0, 99) < 6,
               $urandom_range(0, 99) < 4,
               $urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 6,
               $urandom_range(0, 199) < 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
